// File: rtl/grs_seq_pkg.sv
// Shared types and default constants for the global reset sequencer.
// The state enum doubles as the debug encoding driven out on seq_state.
package grs_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT     = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_GRS_REL    = 3'd3,
        ST_PERIPH_REL = 3'd4,
        ST_RUN        = 3'd5
    } grs_state_t;

    // Default timing constants, in clk cycles.
    localparam int unsigned GRS_HOLD_CYCLES    = 16;
    localparam int unsigned GRS_STABLE_CYCLES  = 64;
    localparam int unsigned GRS_GAP_CYCLES     = 8;
    localparam int unsigned GRS_TIMEOUT_CYCLES = 4096;
    localparam int unsigned GRS_PERIPH_NUM     = 4;

    // Peripheral reset bit positions; release order follows the index.
    localparam int unsigned PERIPH_I2C0  = 0;
    localparam int unsigned PERIPH_I2C1  = 1;
    localparam int unsigned PERIPH_SPI   = 2;
    localparam int unsigned PERIPH_TIMER = 3;

    // Largest of three counts, used to size the shared phase counter.
    function automatic int unsigned grs_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/grs_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// A synchronous active-high clear forces both stages low.
module grs_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw input into the first stage, first stage into the second.
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchronizer stages, cleared while rst is high.
    // NOTE: flops use non-blocking assignments so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/grs_reset_sequencer.sv
// Global reset sequencer: holds GRS_N low for a minimum time, waits for a
// stable synchronized PLL lock, releases GRS_N, then releases the peripheral
// resets one by one at a fixed spacing. Software request or lock loss
// re-enters reset.
// Optional feature macro: GRS_SEQ_LOCK_TIMEOUT_EN adds a WAIT_LOCK timeout
// that sets the sticky lock_timeout flag and retries the sequence.
module grs_reset_sequencer
    import grs_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = GRS_HOLD_CYCLES,
    parameter int unsigned STABLE_CYCLES  = GRS_STABLE_CYCLES,
    parameter int unsigned GAP_CYCLES     = GRS_GAP_CYCLES,
    parameter int unsigned PERIPH_NUM     = GRS_PERIPH_NUM
`ifdef GRS_SEQ_LOCK_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = GRS_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  soft_rst_req,
    output logic                  grs_n,
    output logic [PERIPH_NUM-1:0] periph_rstn,
    output logic                  rst_done,
    output logic                  lock_timeout,
    output logic [2:0]            seq_state
);

    localparam int unsigned CNT_MAX = grs_max3(HOLD_CYCLES, STABLE_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = (PERIPH_NUM > 1) ? $clog2(PERIPH_NUM) : 1;

    grs_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  grs_n_q, grs_n_d;
    logic [PERIPH_NUM-1:0] periph_rstn_q, periph_rstn_d;
    logic                  rst_done_q, rst_done_d;
    logic                  lock_s;

    grs_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

`ifdef GRS_SEQ_LOCK_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            lock_timeout_q, lock_timeout_d;
    logic            to_expired;

    // Count WAIT_LOCK cycles since ASSERT was last left; flag expiry once.
    always_comb begin
        to_expired     = (state_q == ST_WAIT_LOCK) && !lock_s && !soft_rst_req &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        to_cnt_d       = to_cnt_q;
        if (state_q == ST_ASSERT) begin
            to_cnt_d = '0;
        end else if ((state_q == ST_WAIT_LOCK) &&
                     (to_cnt_q != TO_W'(TIMEOUT_CYCLES - 1))) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        lock_timeout_d = lock_timeout_q | to_expired;
    end

    // Timeout counter and sticky flag; only rst clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q       <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign lock_timeout = lock_timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

    // Next-state, counter and registered-output computation.
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        periph_rstn_d = periph_rstn_q;

        if (soft_rst_req) begin
            // Also restarts the hold count when already in ASSERT.
            state_d = ST_ASSERT;
            cnt_d   = '0;
        end else if (!lock_s && ((state_q == ST_GRS_REL) ||
                                 (state_q == ST_PERIPH_REL) ||
                                 (state_q == ST_RUN))) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end
`ifdef GRS_SEQ_LOCK_TIMEOUT_EN
                    else if (to_expired) begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                    end
`endif
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = ST_GRS_REL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GRS_REL: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        // The first peripheral is released on leaving GRS_REL.
                        periph_rstn_d[PERIPH_I2C0] = 1'b1;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = (PERIPH_NUM == 1) ? ST_RUN : ST_PERIPH_REL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PERIPH_REL: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        idx_d                = idx_q + IDX_W'(1);
                        periph_rstn_d[idx_d] = 1'b1;
                        cnt_d                = '0;
                        if (idx_q == IDX_W'(PERIPH_NUM - 2)) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs follow the state being entered so they change on the same edge.
        grs_n_d    = (state_d == ST_GRS_REL) || (state_d == ST_PERIPH_REL) ||
                     (state_d == ST_RUN);
        rst_done_d = (state_d == ST_RUN);
        if (!grs_n_d) begin
            periph_rstn_d = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            idx_q         <= '0;
            grs_n_q       <= 1'b0;
            periph_rstn_q <= '0;
            rst_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            grs_n_q       <= grs_n_d;
            periph_rstn_q <= periph_rstn_d;
            rst_done_q    <= rst_done_d;
        end
    end

    assign grs_n       = grs_n_q;
    assign periph_rstn = periph_rstn_q;
    assign rst_done    = rst_done_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_grs_reset_sequencer.sv
// Directed bench for grs_reset_sequencer at default timing. Cycle numbers
// count rising edges after rst is released; outputs are sampled 1 time unit
// after each edge. Define GRS_SEQ_LOCK_TIMEOUT_EN to add the timeout scenario.
module tb_grs_reset_sequencer;
    import grs_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       grs_n;
    logic [3:0] periph_rstn;
    logic       rst_done;
    logic       lock_timeout;
    logic [2:0] seq_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    grs_reset_sequencer #(
        .HOLD_CYCLES   (16),
        .STABLE_CYCLES (64),
        .GAP_CYCLES    (8),
        .PERIPH_NUM    (4)
`ifdef GRS_SEQ_LOCK_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(32)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .grs_n        (grs_n),
        .periph_rstn  (periph_rstn),
        .rst_done     (rst_done),
        .lock_timeout (lock_timeout),
        .seq_state    (seq_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic g, input logic [3:0] p,
                             input logic d, input grs_state_t s);
        check({tag, ".grs_n"},       32'(grs_n),       32'(g));
        check({tag, ".periph_rstn"}, 32'(periph_rstn), 32'(p));
        check({tag, ".rst_done"},    32'(rst_done),    32'(d));
        check({tag, ".seq_state"},   32'(seq_state),   32'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst          = 1'b1;
        pll_lock     = 1'b1;
        soft_rst_req = 1'b0;
        repeat (3) tick();

        // Reset values.
        check_all("reset", 1'b0, 4'b0000, 1'b0, ST_ASSERT);
        check("reset.lock_timeout", 32'(lock_timeout), 32'(0));

        // Normal power-up with lock high throughout.
        rst = 1'b0;
        cyc = 0;
        run_to(15);  check("hold.c15", 32'(seq_state), 32'(ST_ASSERT));
        run_to(16);  check("hold.c16", 32'(seq_state), 32'(ST_WAIT_LOCK));
        run_to(17);  check("hold.c17", 32'(seq_state), 32'(ST_STABLE));
        run_to(80);  check_all("up.c80",  1'b0, 4'b0000, 1'b0, ST_STABLE);
        run_to(81);  check_all("up.c81",  1'b1, 4'b0000, 1'b0, ST_GRS_REL);
        run_to(88);  check_all("up.c88",  1'b1, 4'b0000, 1'b0, ST_GRS_REL);
        run_to(89);  check_all("up.c89",  1'b1, 4'b0001, 1'b0, ST_PERIPH_REL);
        run_to(96);  check("up.c96",  32'(periph_rstn), 32'(4'b0001));
        run_to(97);  check("up.c97",  32'(periph_rstn), 32'(4'b0011));
        run_to(105); check("up.c105", 32'(periph_rstn), 32'(4'b0111));
        run_to(112); check_all("up.c112", 1'b1, 4'b0111, 1'b0, ST_PERIPH_REL);
        run_to(113); check_all("up.c113", 1'b1, 4'b1111, 1'b1, ST_RUN);

        // Lock glitch during STABLE (lock_s low only in cycle 58, count 40).
        do_reset();
        run_to(55);  pll_lock = 1'b0;
        run_to(56);  pll_lock = 1'b1;
        run_to(57);  check("glitch.c57", 32'(seq_state), 32'(ST_STABLE));
        run_to(58);  check("glitch.c58", 32'(seq_state), 32'(ST_WAIT_LOCK));
        run_to(59);  check("glitch.c59", 32'(seq_state), 32'(ST_STABLE));
        run_to(122); check("glitch.c122", 32'(grs_n), 32'(0));
        run_to(123); check("glitch.c123", 32'(grs_n), 32'(1));
        run_to(154); check("glitch.c154", 32'(rst_done), 32'(0));
        run_to(155); check_all("glitch.c155", 1'b1, 4'b1111, 1'b1, ST_RUN);

        // Software request in RUN: one-cycle reaction, then full sequence again.
        run_to(159); soft_rst_req = 1'b1;
        run_to(160); soft_rst_req = 1'b0;
        check_all("soft.c160", 1'b0, 4'b0000, 1'b0, ST_ASSERT);
        run_to(240); check("soft.c240", 32'(grs_n), 32'(0));
        run_to(241); check("soft.c241", 32'(grs_n), 32'(1));
        run_to(249); check("soft.c249", 32'(periph_rstn), 32'(4'b0001));
        run_to(257); check_all("soft.c257", 1'b1, 4'b0011, 1'b0, ST_PERIPH_REL);

        // Lock loss in PERIPH_REL with two bits released.
        run_to(260); pll_lock = 1'b0;
        run_to(262); check_all("loss.c262", 1'b1, 4'b0011, 1'b0, ST_PERIPH_REL);
        run_to(263); check_all("loss.c263", 1'b0, 4'b0000, 1'b0, ST_ASSERT);
        pll_lock = 1'b1;
        run_to(343); check("loss.c343", 32'(grs_n), 32'(0));
        run_to(344); check_all("loss.c344", 1'b1, 4'b0000, 1'b0, ST_GRS_REL);

        // rst asserted in GRS_REL: reset values on the next edge.
        run_to(346); rst = 1'b1;
        run_to(347);
        check_all("rstmid", 1'b0, 4'b0000, 1'b0, ST_ASSERT);
        check("rstmid.lock_timeout", 32'(lock_timeout), 32'(0));
        do_reset();
        run_to(81);  check("rstmid.c81", 32'(grs_n), 32'(1));

`ifdef GRS_SEQ_LOCK_TIMEOUT_EN
        // Lock held low: timeout after 32 WAIT_LOCK cycles, flag stays set.
        pll_lock = 1'b0;
        do_reset();
        run_to(47);  check("to.c47.state", 32'(seq_state), 32'(ST_WAIT_LOCK));
        check("to.c47.flag", 32'(lock_timeout), 32'(0));
        run_to(48);  check("to.c48.state", 32'(seq_state), 32'(ST_ASSERT));
        check("to.c48.flag", 32'(lock_timeout), 32'(1));
        pll_lock = 1'b1;
        run_to(128); check("to.c128", 32'(grs_n), 32'(0));
        run_to(129); check("to.c129", 32'(grs_n), 32'(1));
        run_to(161); check_all("to.c161", 1'b1, 4'b1111, 1'b1, ST_RUN);
        check("to.c161.flag", 32'(lock_timeout), 32'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grs_reset_sequencer.md
# grs_reset_sequencer

Global reset sequencer driving the `GRS_N` input of the global reset/set primitive and the per-peripheral reset lines of the I2C0, I2C1, SPI and timer blocks. It holds global reset for a minimum time and waits for a stable PLL lock. It then releases global reset, and after that releases peripheral resets one at a time at fixed spacing. It re-enters reset on a software/watchdog request or on PLL lock loss. It sits at the top of the design, between the clock/PLL logic and the global reset primitive.

## Interface
- `HOLD_CYCLES`, 16: minimum cycles in ASSERT after entry.
- `STABLE_CYCLES`, 64: consecutive synced-lock-high cycles required before releasing `grs_n`.
- `GAP_CYCLES`, 8: spacing between `grs_n` release and each `periph_rstn` bit release.
- `PERIPH_NUM`, 4: peripheral reset count; bit 0 I2C0, 1 I2C1, 2 SPI, 3 TIMER.
- `TIMEOUT_CYCLES`, 4096: WAIT_LOCK timeout. Used only with the macro.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `pll_lock` input 1: PLL lock, asynchronous to `clk`.
- `soft_rst_req` input 1: software/watchdog reset request, synchronous, level-sampled.
- `grs_n` output 1: to `GRS_N` of the global reset primitive. Low means reset.
- `periph_rstn` output PERIPH_NUM: per-peripheral resets. Low means reset.
- `rst_done` output 1: high only in RUN.
- `lock_timeout` output 1: sticky WAIT_LOCK timeout flag.
- `seq_state` output 3: current state encoding, for debug.

## Operation
- States: ASSERT, WAIT_LOCK, STABLE, GRS_REL, PERIPH_REL, RUN.
- `pll_lock` passes through a 2-flop synchronizer (`lock_s`). The synchronizer is cleared by `rst`.
- ASSERT: `grs_n`=0, `periph_rstn`=0, `rst_done`=0. Stays exactly HOLD_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK: stays until `lock_s`=1, then goes to STABLE with the counter cleared.
- STABLE: counts consecutive `lock_s`=1 cycles.
  - `lock_s`=0 returns to WAIT_LOCK with the counter cleared.
  - Reaching STABLE_CYCLES goes to GRS_REL.
- GRS_REL: `grs_n`=1 from the first cycle. After GAP_CYCLES goes to PERIPH_REL.
- PERIPH_REL: releases `periph_rstn[i]` in index order, one bit per GAP_CYCLES. The same cycle the last bit is released goes to RUN.
- RUN: `rst_done`=1. Exits to ASSERT on `soft_rst_req`=1 or `lock_s`=0.
- `soft_rst_req`=1 in any non-ASSERT state: go to ASSERT next cycle and clear the counter.
  - In ASSERT, the request restarts the hold count.
- `lock_s`=0 in GRS_REL or PERIPH_REL: go to ASSERT. Partial releases are re-asserted.
- Priority: `rst` > `soft_rst_req` > lock loss > normal progression.
- One shared counter, width `$clog2` of the largest active count parameter, plus a bit index of width `$clog2(PERIPH_NUM)`. Counters never wrap; every state clears the counter on entry.
- Outputs are registered.

## Timing
- Reset values while `rst`=1: state ASSERT, `grs_n`=0, `periph_rstn`=0, `rst_done`=0, `lock_timeout`=0, counter 0, synchronizer 0.
- Cycle 1 is the first cycle with `rst`=0. If `pll_lock` is high throughout, `grs_n` rises at the end of cycle HOLD_CYCLES+1+STABLE_CYCLES (81 at defaults).
- `periph_rstn[i]` rises GAP_CYCLES*(i+1) cycles after `grs_n` (89, 97, 105, 113 at defaults).
- `rst_done` rises with the last bit (113 at defaults).
- Lock-loss reaction: 2 synchronizer cycles plus 1 state cycle. All outputs are low 3 cycles after `pll_lock` falls.
- `soft_rst_req` reaction: 1 cycle.
- `rst` mid-sequence: all outputs take reset values on the next edge.

## Configuration
- `GRS_SEQ_LOCK_TIMEOUT_EN` defined:
  - WAIT_LOCK accumulates cycles since the last ASSERT exit.
  - Reaching TIMEOUT_CYCLES sets `lock_timeout`=1 (sticky, cleared only by `rst`) and goes to ASSERT, which retries the sequence.
- Not defined: WAIT_LOCK waits indefinitely, `lock_timeout` is tied 0, and no timeout counter logic exists.

## Structure
- Package `grs_seq_pkg`: state enum `grs_state_t` (3-bit) and default constants for HOLD/STABLE/GAP/TIMEOUT and the peripheral bit indices.
- Sub-module `grs_sync2`: 2-flop synchronizer with synchronous active-high clear. Used for `pll_lock`.

## Test plan
- Lock high before reset release, defaults:
  - `grs_n` rises at cycle 81.
  - `periph_rstn` = 0001/0011/0111/1111 at cycles 89/97/105/113.
  - `rst_done`=1 at cycle 113.
- Lock glitch low for 1 cycle at STABLE count 40 → returns to WAIT_LOCK. `grs_n` rises 64 cycles after `lock_s` recovers plus 1.
- `soft_rst_req` pulse in RUN → next cycle `grs_n`=0, `periph_rstn`=0, `rst_done`=0, ASSERT. Full sequence repeats.
- `pll_lock` falls in PERIPH_REL after 2 bits are released → all outputs low 3 cycles later, then the sequence restarts.
- `rst` asserted in GRS_REL → next edge: all outputs at reset values, `seq_state`=ASSERT.
- With `GRS_SEQ_LOCK_TIMEOUT_EN`, `TIMEOUT_CYCLES`=32, lock held low → `lock_timeout`=1 after 32 WAIT_LOCK cycles, return to ASSERT. It stays 1 after lock later succeeds and RUN is reached.
